// File: rtl/foo_intf_rr_arbiter.sv
// foo_intf_rr_arbiter: round-robin arbiter for an array of foo_intf requesters
// that share one single-bit resource line.
//
// A one-hot grant is issued one cycle after a request is seen in IDLE. The
// search starts at a rotating priority pointer. The grant is held until
// done[gnt_idx] or MAX_HOLD cycles elapse. The line value of the granted
// element is forwarded on a_out.
//
// Optional feature: define FOO_ARB_LOCK_EN to add a `lock` input. While it is
// high in GRANT, expiry is suppressed, so only done can end the grant.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   req      [N-1:0]  request vector, bit i from foos[i]
//   done     [N-1:0]  release strobe, only bit gnt_idx honoured while granted
//   a_in     [N-1:0]  per-element `a` values
//   gnt      [N-1:0]  one-hot grant or zero
//   gnt_idx  [IW-1:0] index of current or last grant
//   busy     high while in GRANT
//   a_out    a_in[gnt_idx] while busy, else 0
//   timeout  one-cycle pulse when a grant ends by MAX_HOLD expiry
//   lock     (FOO_ARB_LOCK_EN only) suppress expiry while granted
module foo_intf_rr_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned IW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  done,
    input  logic [N-1:0]  a_in,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          busy,
    output logic          a_out,
    output logic          timeout
`ifdef FOO_ARB_LOCK_EN
    ,
    input  logic          lock
`endif
);

    localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned SW = IW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  gnt_d;
    logic [IW-1:0] idx_d;
    logic          to_d;

    logic          found;
    logic [IW-1:0] sel;
    logic [SW-1:0] sum;
    logic          lock_on;
    logic          done_sel;
    logic          expire;

`ifdef FOO_ARB_LOCK_EN
    assign lock_on = lock;
`else
    assign lock_on = 1'b0;
`endif

    assign busy     = (state_q == GRANT);
    assign a_out    = busy & a_in[gnt_idx];
    assign done_sel = done[gnt_idx];
    assign expire   = !lock_on && (cnt_q == CNT_MAX);

    // Rotating scan: first set request at ptr, ptr+1, ... modulo N
    always_comb begin
        found = 1'b0;
        sel   = '0;
        sum   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + SW'(k);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            if (!found && req[sum[IW-1:0]]) begin
                found = 1'b1;
                sel   = sum[IW-1:0];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt;
        idx_d   = gnt_idx;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = N'(1) << sel;
                    idx_d   = sel;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (done_sel || expire) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    to_d    = !done_sel;
                    // Wrap explicitly so a non-power-of-two N never leaves ptr out of range
                    ptr_d   = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
                end else if (!lock_on && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            gnt_idx <= idx_d;
            timeout <= to_d;
        end
    end

endmodule

// File: doc/foo_intf_rr_arbiter.md
Name: foo_intf_rr_arbiter

Overview:
- Round-robin arbiter for an array of foo_intf requester instances (default 8, indexed [7:0]) that share one single-bit resource line.
- Each array element raises a request; the arbiter grants exactly one element at a time, bounds grant length and rotates priority.
- The granted index selects which element's `a` value is forwarded to a shared output; all other elements are ignored.
- Sits between the interface array and the shared consumer; the top-level test drives and checks it.

Parameters:
- N, 8, number of requester interface instances; must be >= 2.
- MAX_HOLD, 4, maximum grant length in cycles; must be >= 1.
- IW, $clog2(N), width of the grant index.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i belongs to foos[i].
- done  input  N  release strobe; only bit gnt_idx is honoured while granted.
- a_in  input  N  per-element `a` values from the interface array.
- gnt  output  N  one-hot grant, or all zeros.
- gnt_idx  output  IW  index of the current or last grant.
- busy  output  1  high while in state GRANT.
- a_out  output  1  equals a_in[gnt_idx] while busy, else 0.
- timeout  output  1  one-cycle pulse when a grant ends by MAX_HOLD expiry.

Behaviour:
- Reset (async assert, any cycle):
  - gnt=0, gnt_idx=0, busy=0, a_out=0, timeout=0.
  - Priority pointer ptr=0, hold counter cnt=0, state=IDLE.
  - An active grant is dropped immediately.
- State IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, ..., wrapping modulo N.
  - On the next edge: gnt=onehot(sel), gnt_idx=sel, cnt=0, state=GRANT. Latency from req to gnt is 1 cycle.
  - If req == 0, stay in IDLE.
- State GRANT:
  - gnt held stable.
  - Each edge, cnt increments, saturating at MAX_HOLD-1.
  - Grant ends on the edge where done[gnt_idx]=1 or cnt==MAX_HOLD-1, whichever comes first.
  - On end: gnt=0, state=IDLE, ptr=(gnt_idx+1) mod N, computed without overflow when gnt_idx==N-1.
  - timeout=1 for that one cycle only if expiry ended the grant and done[gnt_idx] was 0.
  - If done and expiry coincide, done wins and timeout stays 0.
- Mandatory idle gap: at least one cycle with gnt=0 between consecutive grants, even with continuous requests.
- Requester drops req while granted: grant is kept until done or expiry; req is only sampled in IDLE.
- done bits for non-granted indices are ignored.
- gnt_idx keeps its last value in IDLE.
- a_out is combinational from a_in, gated by busy.
- Fairness: with all N requesting continuously, each index is granted once per N grants in ascending order from ptr.

Optional Feature:
- Macro FOO_ARB_LOCK_EN.
- When defined:
  - Adds input port `lock` (width 1).
  - While in GRANT with lock=1, the expiry condition is suppressed: cnt freezes and no timeout is issued. Only done[gnt_idx] ends the grant.
  - lock is ignored in IDLE.
- When undefined:
  - No lock port exists.
  - Grants always end by done or MAX_HOLD as above.

Test Plan:
- Reset, then req=8'h08 held and done[3] pulsed in the 2nd grant cycle -> gnt=8'h08 and gnt_idx=3 one cycle after req; gnt=0 after the done edge; ptr=4.
- req=8'hFF constant, done never asserted, MAX_HOLD=4 -> grants to 0,1,...,7,0 in order; each grant lasts 4 cycles with a 1-cycle gap; timeout pulses once per grant.
- Granted index 7, done[7] pulsed -> next grant (req=8'h81) goes to 0, confirming wrap-around.
- done[gnt_idx] asserted in the same cycle cnt reaches MAX_HOLD-1 -> grant ends, timeout stays 0.
- rst asserted mid-grant (gnt=8'h20) between clock edges -> gnt, busy and a_out go to 0 without waiting for an edge; after release with req=8'h20 the grant returns 1 cycle later via ptr=0 scan.
- With FOO_ARB_LOCK_EN: lock=1 and req=8'h02 held for 10 cycles, then done[1] -> gnt=8'h02 for all 10+ cycles, no timeout, release on the done edge. a_in[1] toggling is mirrored on a_out throughout.
